// File: rtl/mio_cli_link_arb_pkg.sv
// mio_cli_link_arb_pkg
// Shared types and default parameter values for the two-requester
// (bob / alice) packet-granular round-robin link arbiter.
//   state_t   : arbiter FSM states
//   src_t     : requester identity, also the encoding driven on out_src
//   gnt_state : maps a requester to its grant state
package mio_cli_link_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_BOB   = 2'd1,
        GNT_ALICE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_BOB   = 1'b0,
        SRC_ALICE = 1'b1
    } src_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 256;
    localparam int DEF_PKT_CNT_WIDTH  = 16;

    function automatic state_t gnt_state(input src_t src);
        return (src == SRC_ALICE) ? GNT_ALICE : GNT_BOB;
    endfunction

endpackage

// File: rtl/mio_cli_link_arb_rr.sv
// mio_cli_link_arb_rr
// Combinational 2-way round-robin picker. Serves whichever requester is
// active; when both are active the one named by prio wins.
// Ports:
//   req       in   [1:0] request vector, bit 0 = bob, bit 1 = alice
//   prio      in   src_t preferred source when both request
//   gnt_valid out  at least one request present
//   gnt_idx   out  src_t chosen source (SRC_BOB when nothing requests)
module mio_cli_link_arb_rr
    import mio_cli_link_arb_pkg::*;
(
    input  logic [1:0] req,
    input  src_t       prio,
    output logic       gnt_valid,
    output src_t       gnt_idx
);

    // NOTE: every output of an always_comb block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = SRC_BOB;
        unique case (req)
            2'b01:   gnt_idx = SRC_BOB;
            2'b10:   gnt_idx = SRC_ALICE;
            2'b11:   gnt_idx = prio;
            default: gnt_idx = SRC_BOB;
        endcase
    end

endmodule

// File: rtl/mio_cli_link_arb.sv
// mio_cli_link_arb
// Packet-granular round-robin arbiter sharing one Moore.io CLI valid/ready
// link between the bob and alice requesters. The grant is locked from the
// first beat through the `last` beat; the link is a zero-latency
// combinational pass-through of the granted stream. Completed packets are
// counted per source (wrap-around).
// Optional feature macro: MIO_CLI_LINK_ARB_TIMEOUT_EN -- when defined, a
// granted packet that sees TIMEOUT_CYCLES consecutive cycles without a
// valid beat is aborted (timeout_err pulses, no packet counted).
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   bob_valid/last/data, bob_ready  bob request stream
//   alice_valid/last/data, alice_ready  alice request stream
//   out_valid/last/data, out_ready  shared downstream link
//   out_src                         owner of current beat (0=bob, 1=alice)
//   pkt_cnt_bob, pkt_cnt_alice      completed packet counters
//   timeout_err                     one-cycle abort pulse
module mio_cli_link_arb
    import mio_cli_link_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PKT_CNT_WIDTH  = DEF_PKT_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     bob_valid,
    input  logic                     bob_last,
    input  logic [DATA_WIDTH-1:0]    bob_data,
    output logic                     bob_ready,
    input  logic                     alice_valid,
    input  logic                     alice_last,
    input  logic [DATA_WIDTH-1:0]    alice_data,
    output logic                     alice_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_src,
    input  logic                     out_ready,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_bob,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_alice,
    output logic                     timeout_err
);

    state_t state;
    src_t   prio;
    src_t   cur_src;
    src_t   other_src;
    src_t   pick_prio;
    src_t   pick_idx;
    logic   pick_valid;
    logic   granted;
    logic   accept;
    logic   pkt_end;
    logic   timeout_hit;

    assign granted   = (state == GNT_BOB) || (state == GNT_ALICE);
    assign cur_src   = (state == GNT_ALICE) ? SRC_ALICE : SRC_BOB;
    assign other_src = (cur_src == SRC_ALICE) ? SRC_BOB : SRC_ALICE;

    // In IDLE the stored pointer decides a tie. At a packet end the other
    // source is preferred, which is exactly "other valid -> other, else this
    // valid -> this". The ending beat's own valid counts, so a source that
    // keeps streaming single-beat packets keeps the link with no bubble
    // until the other source asks.
    assign pick_prio = granted ? other_src : prio;

    mio_cli_link_arb_rr u_rr (
        .req       ({alice_valid, bob_valid}),
        .prio      (pick_prio),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Link pass-through; everything reads zero outside a grant, so an
    // asynchronous reset (state -> IDLE) clears the link immediately.
    always_comb begin
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        out_src     = 1'b0;
        bob_ready   = 1'b0;
        alice_ready = 1'b0;
        unique case (state)
            GNT_BOB: begin
                out_valid = bob_valid;
                out_last  = bob_last;
                out_data  = bob_data;
                out_src   = SRC_BOB;
                bob_ready = out_ready;
            end
            GNT_ALICE: begin
                out_valid   = alice_valid;
                out_last    = alice_last;
                out_data    = alice_data;
                out_src     = SRC_ALICE;
                alice_ready = out_ready;
            end
            default: ;
        endcase
    end

    assign accept  = out_valid && out_ready;
    assign pkt_end = accept && out_last;

`ifdef MIO_CLI_LINK_ARB_TIMEOUT_EN
    localparam int IDLE_W = 16;
    logic [IDLE_W-1:0] idle_cnt;

    // Fires in the cycle that would bring the idle count to TIMEOUT_CYCLES.
    assign timeout_hit = granted && !out_valid
                         && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_hit;

    // Cleared while IDLE so every grant entry starts from zero; a handoff
    // entry is covered by the accepted last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!granted || accept) begin
            idle_cnt <= '0;
        end else if (!out_valid) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            prio          <= SRC_BOB;
            pkt_cnt_bob   <= '0;
            pkt_cnt_alice <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= gnt_state(pick_idx);
                    end
                end
                GNT_BOB, GNT_ALICE: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                        prio  <= (prio == SRC_BOB) ? SRC_ALICE : SRC_BOB;
                    end else if (pkt_end) begin
                        if (cur_src == SRC_BOB) begin
                            pkt_cnt_bob <= pkt_cnt_bob + PKT_CNT_WIDTH'(1);
                        end else begin
                            pkt_cnt_alice <= pkt_cnt_alice + PKT_CNT_WIDTH'(1);
                        end
                        prio  <= other_src;
                        state <= pick_valid ? gnt_state(pick_idx) : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_cli_link_arb.sv
// tb_mio_cli_link_arb
// Directed bench for mio_cli_link_arb: reset, single packet, interleaved
// packets, downstream stall, mid-packet valid drop (with and without
// MIO_CLI_LINK_ARB_TIMEOUT_EN), asynchronous reset mid-packet, and
// packet counter wrap. Inputs change 1 ns after the rising edge; outputs
// are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mio_cli_link_arb;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bob_valid, bob_last, alice_valid, alice_last;
    logic [DW-1:0] bob_data, alice_data;
    logic          bob_ready, alice_ready;
    logic          out_valid, out_last, out_src, out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pkt_cnt_bob, pkt_cnt_alice;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mio_cli_link_arb #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4),
        .PKT_CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bob_valid     (bob_valid),
        .bob_last      (bob_last),
        .bob_data      (bob_data),
        .bob_ready     (bob_ready),
        .alice_valid   (alice_valid),
        .alice_last    (alice_last),
        .alice_data    (alice_data),
        .alice_ready   (alice_ready),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_ready     (out_ready),
        .pkt_cnt_bob   (pkt_cnt_bob),
        .pkt_cnt_alice (pkt_cnt_alice),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; out_ready = 1'b0;
        bob_valid = 1'b1; bob_last = 1'b0; bob_data = '0;
        alice_valid = 1'b0; alice_last = 1'b0; alice_data = '0;
        repeat (2) next();

        // Reset state (bob already valid must not leak through)
        sample();
        check("rst_out_valid", out_valid, 0);
        check("rst_bob_ready", bob_ready, 0);
        check("rst_alice_ready", alice_ready, 0);
        check("rst_cnt_bob", pkt_cnt_bob, 0);
        check("rst_cnt_alice", pkt_cnt_alice, 0);
        check("rst_timeout", timeout_err, 0);

        // Bob 3-beat packet
        next(); reset_n = 1'b1; bob_data = 32'hA0; out_ready = 1'b1;
        sample(); check("t1_idle_valid", out_valid, 0);
        check("t1_idle_ready", bob_ready, 0);
        next();
        sample(); check("t1_b0_valid", out_valid, 1);
        check("t1_b0_data", out_data, 32'hA0);
        check("t1_b0_src", out_src, 0);
        check("t1_b0_ready", bob_ready, 1);
        check("t1_b0_aready", alice_ready, 0);
        next(); bob_data = 32'hA1;
        sample(); check("t1_b1_data", out_data, 32'hA1);
        check("t1_b1_last", out_last, 0);
        next(); bob_data = 32'hA2; bob_last = 1'b1;
        sample(); check("t1_b2_data", out_data, 32'hA2);
        check("t1_b2_last", out_last, 1);
        next(); bob_valid = 1'b0; bob_last = 1'b0;
        sample(); check("t1_cnt_bob", pkt_cnt_bob, 1);
        check("t1_done_valid", out_valid, 0);

        // Both requesters, 2-beat packets each, alternating with no bubble
        next(); reset_n = 1'b0;
        sample(); check("t2_rst_cnt", pkt_cnt_bob, 0);
        next(); reset_n = 1'b1;
        bob_valid = 1'b1; bob_data = 32'hB0; alice_valid = 1'b1; alice_data = 32'hC0;
        sample(); check("t2_idle_valid", out_valid, 0);
        next();
        sample(); check("t2_p1_src", out_src, 0); check("t2_p1_data", out_data, 32'hB0);
        next(); bob_data = 32'hB1; bob_last = 1'b1;
        sample(); check("t2_p1b_data", out_data, 32'hB1); check("t2_p1b_last", out_last, 1);
        next(); bob_data = 32'hB2; bob_last = 1'b0;
        sample(); check("t2_p2_src", out_src, 1); check("t2_p2_data", out_data, 32'hC0);
        check("t2_p2_valid", out_valid, 1);
        check("t2_p2_aready", alice_ready, 1); check("t2_p2_bready", bob_ready, 0);
        check("t2_cnt_bob1", pkt_cnt_bob, 1);
        next(); alice_data = 32'hC1; alice_last = 1'b1;
        sample(); check("t2_p2b_data", out_data, 32'hC1);
        next(); alice_data = 32'hC2; alice_last = 1'b0;
        sample(); check("t2_p3_src", out_src, 0); check("t2_p3_data", out_data, 32'hB2);
        check("t2_cnt_alice1", pkt_cnt_alice, 1);
        next(); bob_data = 32'hB3; bob_last = 1'b1;
        sample(); check("t2_p3b_data", out_data, 32'hB3);
        next(); bob_valid = 1'b0; bob_last = 1'b0;
        sample(); check("t2_p4_src", out_src, 1); check("t2_p4_data", out_data, 32'hC2);
        check("t2_cnt_bob2", pkt_cnt_bob, 2);

        // Alice last beat stalled 10 cycles while bob waits
        next(); alice_data = 32'hC3; alice_last = 1'b1; out_ready = 1'b0;
        bob_valid = 1'b1; bob_data = 32'hD0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("t3_aready", alice_ready, 0);
            check("t3_bready", bob_ready, 0);
            check("t3_data", out_data, 32'hC3);
            check("t3_src", out_src, 1);
            next();
        end
        out_ready = 1'b1;
        sample(); check("t3_release_aready", alice_ready, 1);
        check("t3_release_last", out_last, 1);
        next(); alice_valid = 1'b0; alice_last = 1'b0;
        sample(); check("t3_cnt_alice2", pkt_cnt_alice, 2);
        check("t3_bob_src", out_src, 0); check("t3_bob_data", out_data, 32'hD0);
        check("t3_bob_ready", bob_ready, 1);

        // Bob drops valid mid-packet; alice requests meanwhile
        next(); bob_valid = 1'b0; alice_valid = 1'b1; alice_data = 32'hE0;
`ifdef MIO_CLI_LINK_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t4_to_early", timeout_err, 0);
            check("t4_to_aready", alice_ready, 0);
            next();
        end
        sample(); check("t4_to_pulse", timeout_err, 1);
        next();
        sample(); check("t4_to_clear", timeout_err, 0);
        check("t4_to_idle", out_valid, 0);
        check("t4_to_cnt_bob", pkt_cnt_bob, 2);
        next();
        sample(); check("t4_to_alice_src", out_src, 1);
        check("t4_to_alice_data", out_data, 32'hE0);
`else
        for (int i = 0; i < 100; i++) begin
            sample();
            check("t4_hold_aready", alice_ready, 0);
            check("t4_hold_valid", out_valid, 0);
            check("t4_hold_timeout", timeout_err, 0);
            next();
        end
        bob_valid = 1'b1; bob_data = 32'hD1; bob_last = 1'b1;
        sample(); check("t4_resume_data", out_data, 32'hD1);
        check("t4_resume_ready", bob_ready, 1);
        next(); bob_valid = 1'b0; bob_last = 1'b0;
        sample(); check("t4_cnt_bob3", pkt_cnt_bob, 3);
        check("t4_alice_src", out_src, 1);
        check("t4_alice_data", out_data, 32'hE0);
        check("t4_alice_ready", alice_ready, 1);
`endif

        // Asynchronous reset in the middle of alice's packet
        next(); alice_data = 32'hE1;
        sample(); check("t5_pre_data", out_data, 32'hE1);
        #2; reset_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_aready", alice_ready, 0);
        check("t5_async_src", out_src, 0);
        check("t5_async_cnt_bob", pkt_cnt_bob, 0);
        check("t5_async_cnt_alice", pkt_cnt_alice, 0);
        next(); reset_n = 1'b1; alice_data = 32'hF0; alice_last = 1'b1;
        sample(); check("t5_idle_valid", out_valid, 0);
        next();
        sample(); check("t5_alice_src", out_src, 1);
        check("t5_alice_data", out_data, 32'hF0);
        check("t5_alice_ready", alice_ready, 1);
        next(); alice_valid = 1'b0; alice_last = 1'b0;
        sample(); check("t5_cnt_alice", pkt_cnt_alice, 1);

        // Bob counter wrap with back-to-back single-beat packets
        next(); reset_n = 1'b0; bob_valid = 1'b1; bob_last = 1'b1; bob_data = 32'h55;
        next(); reset_n = 1'b1;
        next();
        repeat (65535) next();
        sample(); check("t6_cnt_ffff", pkt_cnt_bob, 16'hFFFF);
        check("t6_valid", out_valid, 1);
        next();
        sample(); check("t6_cnt_wrap", pkt_cnt_bob, 16'h0000);
        check("t6_cnt_alice", pkt_cnt_alice, 0);
        bob_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
